// File: rtl/fifo_pkg.sv
// Shared definitions for the serial FIFO read/write companions.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNTW  = 16;

endpackage

// File: rtl/fifo_word_reader.sv
// Drains a 1-bit FIFO and packs WIDTH bits LSB-first into a word,
// delivered over a valid/ready handshake; flush discards any partial word.
module fifo_word_reader
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNTW  = DEF_CNTW
) (
  input  logic             clk_out,
  input  logic             rst,
  input  logic             flush,
  input  logic             empty,
  input  logic             dataOut,
  output logic             remove,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic [CNTW-1:0]  word_count
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t        state, state_nx;
  logic [CW-1:0] req_cnt, got_cnt;
  logic          pend;
  logic          last_cap;
  logic          handshake;

  assign last_cap   = pend && (got_cnt == CW'(WIDTH - 1));
  assign handshake  = (state == HOLD) && word_ready;
  assign word_valid = (state == HOLD);
  assign busy       = (state == FILL);

  always_ff @(posedge clk_out) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    remove   = 1'b0;
    unique case (state)
      IDLE: if (!empty) state_nx = FILL;
      FILL: begin
        remove = !empty && (req_cnt < CW'(WIDTH)) && !flush;
        if (last_cap) state_nx = HOLD;
      end
      HOLD: if (word_ready) state_nx = empty ? IDLE : FILL;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // pend marks a bit in flight: FIFO data arrives one cycle after remove.
  always_ff @(posedge clk_out) begin
    if (rst || flush) begin
      word       <= '0;
      req_cnt    <= '0;
      got_cnt    <= '0;
      pend       <= 1'b0;
      word_count <= '0;
    end else begin
      pend <= remove;
      if (remove) req_cnt <= req_cnt + CW'(1);
      if (pend) begin
        for (int unsigned i = 0; i < WIDTH; i++)
          if (got_cnt == CW'(i)) word[i] <= dataOut;
        got_cnt <= got_cnt + CW'(1);
      end
      if (handshake) begin
        word_count <= word_count + CNTW'(1);
        req_cnt    <= '0;
        got_cnt    <= '0;
        word       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_word_reader.sv
// Self-checking bench: FIFO bit-queue model plus expected-word scoreboard.
module tb_fifo_word_reader;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          clk_out = 1'b0;
  logic          rst, flush, empty, dataOut, remove;
  logic [W-1:0]  word;
  logic          word_valid, word_ready, busy;
  logic [CW-1:0] word_count;

  always #5 clk_out = ~clk_out;

  fifo_word_reader #(.WIDTH(W), .CNTW(CW)) dut (
    .clk_out   (clk_out),
    .rst       (rst),
    .flush     (flush),
    .empty     (empty),
    .dataOut   (dataOut),
    .remove    (remove),
    .word      (word),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .busy      (busy),
    .word_count(word_count)
  );

  int checks = 0, errors = 0;

  bit           src[$];
  logic [W-1:0] expw[$];
  logic [W-1:0] acc;
  int           accn, mcnt, pops, hs_n;
  bit           gap, prev_hold;
  logic [W-1:0] prev_word;
  logic         s_remove, s_wv, s_busy;
  logic [W-1:0] s_word;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_bit(bit b);
    src.push_back(b);
    acc[accn] = b;
    accn++;
    if (accn == W) begin
      expw.push_back(acc);
      accn = 0;
      acc  = '0;
    end
  endtask

  task automatic push_random(int n);
    for (int i = 0; i < n; i++) push_bit(1'($urandom));
  endtask

  task automatic clear_model();
    src.delete();
    expw.delete();
    accn = 0;
    acc  = '0;
    mcnt = 0;
  endtask

  // One clock cycle: drive empty, sample at negedge, update model, return at posedge+1.
  task automatic cyc();
    bit rm, hs, b;
    b = 1'b0;
    empty = gap || (src.size() == 0);
    @(negedge clk_out);
    s_remove = remove; s_wv = word_valid; s_busy = busy; s_word = word;
    if (remove === 1'b1) check_eq("remove_while_empty", empty, 0);
    if (!rst) check_eq("word_count", word_count, mcnt);
    if (prev_hold && !rst) begin
      check_eq("hold_valid", word_valid, 1);
      check_eq("hold_word", word, prev_word);
    end
    rm = (remove === 1'b1) && !empty && !rst;
    hs = (word_valid === 1'b1) && word_ready && !flush && !rst;
    if (hs) begin
      hs_n++;
      check_eq("word_avail", expw.size() != 0, 1);
      if (expw.size() != 0) check_eq("word", word, expw.pop_front());
      mcnt = (mcnt + 1) % (1 << CW);
    end
    prev_hold = (word_valid === 1'b1) && !word_ready && !flush && !rst;
    prev_word = word;
    if (rm) begin
      b = src.pop_front();
      pops++;
    end
    if (rst || flush) clear_model();
    @(posedge clk_out);
    #1;
    dataOut = rm ? b : 1'($urandom);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  task automatic wait_valid(string tag);
    int n = 0;
    while (!s_wv && n < 80) begin cyc(); n++; end
    check_eq(tag, s_wv, 1);
  endtask

  task automatic wait_words(string tag, int n_words, int bound);
    int h0 = hs_n;
    for (int i = 0; i < bound && hs_n < h0 + n_words; i++) cyc();
    check_eq(tag, hs_n - h0, n_words);
  endtask

  initial begin
    logic [15:0]  rmv, wvv, bsv;
    logic [W-1:0] held, w0;
    bit           done;
    int           pushed, h0;
    logic [7:0]   pat;

    rst = 1'b1; flush = 1'b0; gap = 1'b0; word_ready = 1'b0; dataOut = 1'b0;
    prev_hold = 1'b0; accn = 0; acc = '0; mcnt = 0; pops = 0; hs_n = 0;
    s_wv = 1'b0;
    repeat (3) cyc();
    check_eq("rst_remove", s_remove, 0);
    check_eq("rst_word", s_word, 0);
    check_eq("rst_valid", s_wv, 0);
    check_eq("rst_busy", s_busy, 0);
    check_eq("rst_count", word_count, 0);
    rst = 1'b0;
    cyc();

    // Basic word: bits 1,0,1,1,0,0,1,0 first-to-last.
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) push_bit(pat[i]);
    word_ready = 1'b1;
    rmv = '0; wvv = '0; bsv = '0; w0 = '0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      rmv[i] = s_remove; wvv[i] = s_wv; bsv[i] = s_busy;
      if (s_wv) w0 = s_word;
    end
    check_eq("t1_remove_cycles", rmv, 16'h01FE);
    check_eq("t1_valid_cycles", wvv, 16'h0400);
    check_eq("t1_busy_cycles", bsv, 16'h03FE);
    check_eq("t1_word", w0, 8'h4D);
    check_eq("t1_count", word_count, 1);

    // Back-pressure: word held with ready low for 20 cycles.
    word_ready = 1'b0;
    do_flush();
    push_random(W);
    cyc();
    wait_valid("t2_timeout");
    held = s_word;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check_eq("t2_hold", {s_wv, s_remove, s_word}, {1'b1, 1'b0, held});
    end
    word_ready = 1'b1;
    cyc();
    word_ready = 1'b0;
    cyc();
    check_eq("t2_count", word_count, 1);

    // Empty gap of 5 cycles after the third bit is read.
    do_flush();
    push_random(W);
    word_ready = 1'b1;
    pops = 0; done = 1'b0; h0 = hs_n;
    for (int i = 0; i < 100 && hs_n == h0; i++) begin
      cyc();
      if (pops == 3 && !done) begin
        done = 1'b1;
        gap  = 1'b1;
        for (int k = 0; k < 5; k++) begin
          cyc();
          check_eq("t3_gap_remove", s_remove, 0);
        end
        gap = 1'b0;
      end
    end
    check_eq("t3_word_done", hs_n - h0, 1);

    // Flush after 5 captured bits; next word built only from new bits.
    do_flush();
    push_random(W);
    pops = 0;
    for (int i = 0; i < 40 && pops < 5; i++) cyc();
    gap = 1'b1;
    cyc();
    check_eq("t4_busy_before", s_busy, 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    gap = 1'b0;
    cyc();
    check_eq("t4_busy_after", s_busy, 0);
    check_eq("t4_valid_after", s_wv, 0);
    push_random(W);
    wait_words("t4_new_word", 1, 60);

    // Flush coincident with handshake.
    do_flush();
    word_ready = 1'b0;
    push_random(W);
    cyc();
    wait_valid("t5_timeout");
    word_ready = 1'b1;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    word_ready = 1'b0;
    cyc();
    check_eq("t5_count", word_count, 0);
    check_eq("t5_idle", {s_busy, s_wv}, 2'b00);

    // Random empty/ready over 1000 words.
    do_flush();
    pushed = 0; h0 = hs_n;
    for (int i = 0; i < 60000 && hs_n < h0 + 1000; i++) begin
      gap        = ($urandom_range(0, 9) < 3);
      word_ready = 1'($urandom_range(0, 1));
      if (pushed < 1000 * W && $urandom_range(0, 3) != 0) begin
        int n = $urandom_range(1, 2);
        for (int k = 0; k < n && pushed < 1000 * W; k++) begin
          push_bit(1'($urandom));
          pushed++;
        end
      end
      cyc();
    end
    check_eq("t6_words", hs_n - h0, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
